attitude_wb_stream: RTL and testbench

Parametrised Wishbone front-end for the attitude-sensor peripherals in SweRVolf. It buffers multiple sensor samples in an input FIFO and feeds them to a generic valid/ready compute core, such as the Madgwick filter, one sample per transaction. It captures each result into readable registers. Over a single-shot wrapper it adds continuous mode, sample queuing, overflow detection and an interrupt.

---
 rtl/attitude_wb_stream.sv | 225 ++++++++++++++++++++++
 tb/tb_attitude_wb_stream.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/attitude_wb_stream.sv
// attitude_wb_stream
// Wishbone front-end for attitude-sensor compute cores. Samples are staged in
// registers, committed into an input FIFO, handed one at a time to a
// valid/ready compute core, and the results are captured into readable
// registers.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   adr_i/dat_i/dat_o        Wishbone byte address, write data, registered read data
//   we_i/stb_i/cyc_i/ack_o   Wishbone controls, single-cycle acknowledge
//   irq_o                    level interrupt (irq_en & done)
//   core_rst_n_o             core reset, active-low, follows enable one cycle late
//   core_valid_o/ready_i     sample handshake, core_data_o = FIFO head
//   core_valid_i/ready_o     result handshake, core_data_i = result channels
//
// Optional feature: define ATT_WB_TIMESTAMP_EN to add a free-running cycle
// counter that is latched into TIMESTAMP (0x0C) on every result capture.
//
// state  | meaning
// IDLE   | waiting for enable, a queued sample and (cont or pending start)
// ISSUE  | core_valid_o high with FIFO head, waiting for core_ready_i
// WAIT   | core_ready_o high, waiting for the core result
// DONE   | one-cycle completion state
module attitude_wb_stream #(
  parameter int IN_CH  = 6,
  parameter int IN_W   = 16,
  parameter int OUT_CH = 4,
  parameter int OUT_W  = 32,
  parameter int DEPTH  = 4,
  parameter int ADR_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADR_W-1:0]        adr_i,
  input  logic [31:0]             dat_i,
  output logic [31:0]             dat_o,
  input  logic                    we_i,
  input  logic                    stb_i,
  input  logic                    cyc_i,
  output logic                    ack_o,
  output logic                    irq_o,
  output logic                    core_rst_n_o,
  output logic                    core_valid_o,
  input  logic                    core_ready_i,
  output logic [IN_CH*IN_W-1:0]   core_data_o,
  input  logic                    core_valid_i,
  output logic                    core_ready_o,
  input  logic [OUT_CH*OUT_W-1:0] core_data_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = IN_CH * IN_W;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           state_q;
  logic             valid_q, ready_q, start_pend_q;
  logic             ack_q, en_q, cont_q, irq_en_q, done_q, ovf_q, core_rst_n_q;
  logic [31:0]      dat_q, rd_data;
  logic [IN_W-1:0]  stg_q [IN_CH];
  logic [OUT_W-1:0] res_q [OUT_CH];
  logic [SW-1:0]    mem_q [DEPTH];
  logic [SW-1:0]    sample;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic [31:0]      wa;
  logic             req, wr, wr_ctrl, wr_stat, wr_commit;
  logic             full, empty, busy, push, pop, capture;
  logic             unused_dat;

  assign unused_dat = ^dat_i;

  // A new request is only taken when no ack is outstanding, so ack is one cycle wide.
  assign req       = cyc_i && stb_i && !ack_q;
  assign wr        = req && we_i;
  assign wa        = 32'(adr_i) >> 2;
  assign wr_ctrl   = wr && (wa == 32'd0);
  assign wr_stat   = wr && (wa == 32'd1);
  assign wr_commit = wr && (wa == 32'd2);

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign busy    = (state_q != S_IDLE);
  assign push    = wr_commit && en_q && !full;
  assign pop     = en_q && (state_q == S_ISSUE) && valid_q && core_ready_i;
  assign capture = en_q && (state_q == S_WAIT) && ready_q && core_valid_i;

`ifdef ATT_WB_TIMESTAMP_EN
  logic [31:0] ts_cnt_q, ts_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      if (capture) ts_q <= ts_cnt_q;
    end
  end
`endif

  always_comb begin
    sample = '0;
    for (int i = 0; i < IN_CH; i++) sample[i*IN_W +: IN_W] = stg_q[i];
  end

  always_comb begin
    rd_data = '0;
    if (wa == 32'd0)
      rd_data = {28'd0, irq_en_q, cont_q, 1'b0, en_q};
    else if (wa == 32'd1)
      rd_data = {16'd0, 8'(level_q), 3'd0, ovf_q, empty, full, done_q, busy};
`ifdef ATT_WB_TIMESTAMP_EN
    else if (wa == 32'd3)
      rd_data = ts_q;
`endif
    for (int i = 0; i < IN_CH; i++)
      if (wa == 32'(4 + i)) rd_data = 32'(stg_q[i]);
    for (int j = 0; j < OUT_CH; j++)
      if (wa == 32'(32 + j)) rd_data = 32'(res_q[j]);
  end

  // Bus side, control, staging, results and sticky status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q        <= 1'b0;
      dat_q        <= '0;
      en_q         <= 1'b0;
      cont_q       <= 1'b0;
      irq_en_q     <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      core_rst_n_q <= 1'b0;
      for (int i = 0; i < IN_CH; i++) stg_q[i] <= '0;
      for (int j = 0; j < OUT_CH; j++) res_q[j] <= '0;
    end else begin
      ack_q        <= req;
      core_rst_n_q <= en_q;
      if (req) dat_q <= rd_data;
      if (wr_ctrl) begin
        en_q     <= dat_i[0];
        cont_q   <= dat_i[2];
        irq_en_q <= dat_i[3];
      end
      for (int i = 0; i < IN_CH; i++)
        if (wr && (wa == 32'(4 + i))) stg_q[i] <= dat_i[IN_W-1:0];
      if (capture)
        for (int j = 0; j < OUT_CH; j++) res_q[j] <= core_data_i[j*OUT_W +: OUT_W];
      // Set has priority over a simultaneous W1C.
      if (wr_stat && dat_i[1]) done_q <= 1'b0;
      if (capture) done_q <= 1'b1;
      if (wr_stat && dat_i[4]) ovf_q <= 1'b0;
      if (wr_commit && en_q && full) ovf_q <= 1'b1;
    end
  end

  // Input FIFO, held flushed while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int d = 0; d < DEPTH; d++) mem_q[d] <= '0;
    end else if (!en_q) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= sample;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      valid_q      <= 1'b0;
      ready_q      <= 1'b0;
      start_pend_q <= 1'b0;
    end else if (!en_q) begin
      state_q      <= S_IDLE;
      valid_q      <= 1'b0;
      ready_q      <= 1'b0;
      start_pend_q <= wr_ctrl && dat_i[0] && dat_i[1];
    end else begin
      case (state_q)
        S_IDLE:
          if (!empty && (cont_q || start_pend_q)) begin
            state_q      <= S_ISSUE;
            valid_q      <= 1'b1;
            start_pend_q <= 1'b0;
          end
        S_ISSUE:
          if (core_ready_i) begin
            state_q <= S_WAIT;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        S_WAIT:
          if (core_valid_i) begin
            state_q <= S_DONE;
            ready_q <= 1'b0;
          end
        default:
          state_q <= S_IDLE;
      endcase
      // A start arriving as a sample is issued stays pending for the next one.
      if (wr_ctrl && dat_i[1]) start_pend_q <= 1'b1;
    end
  end

  assign ack_o        = ack_q;
  assign dat_o        = dat_q;
  assign irq_o        = irq_en_q & done_q;
  assign core_rst_n_o = core_rst_n_q;
  assign core_valid_o = valid_q;
  assign core_ready_o = ready_q;
  assign core_data_o  = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_attitude_wb_stream.sv
module tb_attitude_wb_stream;
  localparam int IN_CH = 6, IN_W = 16, OUT_CH = 4, OUT_W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  adr_i;
  logic [31:0] dat_i, dat_o;
  logic        we_i, stb_i, cyc_i, ack_o, irq_o;
  logic        core_rst_n_o, core_valid_o, core_ready_i;
  logic [IN_CH*IN_W-1:0]   core_data_o;
  logic        core_valid_i, core_ready_o;
  logic [OUT_CH*OUT_W-1:0] core_data_i;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  logic [IN_CH*IN_W-1:0] exp_q[$];
  logic [15:0]           stg_m [IN_CH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  attitude_wb_stream dut (
    .clk(clk), .rst(rst), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .we_i(we_i), .stb_i(stb_i), .cyc_i(cyc_i), .ack_o(ack_o), .irq_o(irq_o),
    .core_rst_n_o(core_rst_n_o), .core_valid_o(core_valid_o),
    .core_ready_i(core_ready_i), .core_data_o(core_data_o),
    .core_valid_i(core_valid_i), .core_ready_o(core_ready_o),
    .core_data_i(core_data_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: timeout waiting for DUT", tag);
  endtask

  task automatic wb_cycle(input logic [7:0] a, input logic [31:0] d, input logic w,
                          output logic [31:0] r);
    bit got = 1'b0;
    @(negedge clk);
    adr_i = a; dat_i = d; we_i = w; cyc_i = 1'b1; stb_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (ack_o) begin got = 1'b1; break; end
    end
    r = dat_o;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    if (!got) timeout_fail("wb_ack");
  endtask

  task automatic wb_write(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] unused_r;
    wb_cycle(a, d, 1'b1, unused_r);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] r;
    wb_cycle(a, 32'd0, 1'b0, r);
    chk(tag, r, exp);
  endtask

  task automatic stage(input int ch, input logic [15:0] v);
    stg_m[ch] = v;
    wb_write(8'h10 + 8'(4 * ch), {16'd0, v});
  endtask

  task automatic commit(input bit expect_kept);
    logic [IN_CH*IN_W-1:0] s;
    for (int c = 0; c < IN_CH; c++) s[c*IN_W +: IN_W] = stg_m[c];
    if (expect_kept) exp_q.push_back(s);
    wb_write(8'h08, 32'd0);
  endtask

  function automatic logic [OUT_CH*OUT_W-1:0] res_of(input logic [IN_CH*IN_W-1:0] s);
    logic [OUT_CH*OUT_W-1:0] r;
    for (int j = 0; j < OUT_CH; j++) r[j*OUT_W +: OUT_W] = 32'(s[15:0]) + 32'(9 + j);
    return r;
  endfunction

  // Waits for an issued sample, pops the scoreboard and accepts it.
  task automatic wait_issue(output logic [IN_CH*IN_W-1:0] s);
    bit got = 1'b0;
    s = '0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (core_valid_o) begin got = 1'b1; break; end
    end
    if (!got) timeout_fail("core_valid");
    else if (exp_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL sb_underflow: observed issued sample expected none");
    end else begin
      s = exp_q.pop_front();
      for (int c = 0; c < IN_CH; c++)
        chk("core_data", 32'(core_data_o[c*IN_W +: IN_W]), 32'(s[c*IN_W +: IN_W]));
    end
    core_ready_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic give_result(input logic [OUT_CH*OUT_W-1:0] r, input int min_cyc,
                             output int at);
    bit got = 1'b0;
    at = 0;
    for (int k = 0; k < 200; k++) begin
      if (core_ready_o) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) timeout_fail("core_ready");
    else begin
      while (cyc_cnt < min_cyc) @(negedge clk);
      core_data_i = r; core_valid_i = 1'b1; at = cyc_cnt;
      @(negedge clk);
      core_valid_i = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $error("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [IN_CH*IN_W-1:0] s;
    logic [31:0] t1, t2;
    int c1, c2;

    rst = 1'b1; adr_i = '0; dat_i = '0; we_i = 1'b0; stb_i = 1'b0; cyc_i = 1'b0;
    core_ready_i = 1'b0; core_valid_i = 1'b0; core_data_i = '0;
    for (int c = 0; c < IN_CH; c++) stg_m[c] = '0;
    repeat (3) @(negedge clk);
    chk("rst_irq", 32'(irq_o), 32'd0);
    chk("rst_core_rst_n", 32'(core_rst_n_o), 32'd0);
    chk("rst_core_valid", 32'(core_valid_o), 32'd0);
    chk("rst_ack", 32'(ack_o), 32'd0);
    rst = 1'b0;
    rd_chk("rst_ctrl", 8'h00, 32'd0);
    rd_chk("rst_status", 8'h04, 32'h08);
    rd_chk("rst_res0", 8'h80, 32'd0);

    // Enable; core reset releases one cycle after enable takes effect.
    wb_write(8'h00, 32'h1);
    chk("core_rst_n_lag", 32'(core_rst_n_o), 32'd0);
    @(posedge clk); #1;
    chk("core_rst_n_up", 32'(core_rst_n_o), 32'd1);

    // Staging width, unmapped access, single shot.
    wb_write(8'h10, 32'hFFFF1234);
    rd_chk("stg_zext", 8'h10, 32'h1234);
    wb_write(8'h70, 32'hDEADBEEF);
    rd_chk("unmapped", 8'h70, 32'd0);
    for (int c = 0; c < IN_CH; c++) stage(c, 16'(c + 1));
    commit(1'b1);
    wb_write(8'h00, 32'h3);
    wait_issue(s);
    give_result(res_of(s), 0, c1);
    repeat (2) @(negedge clk);
    for (int j = 0; j < OUT_CH; j++) rd_chk("res_single", 8'h80 + 8'(4 * j), 32'hA + 32'(j));
    rd_chk("status_done", 8'h04, 32'h0A);
    chk("irq_disabled", 32'(irq_o), 32'd0);
    wb_write(8'h04, 32'h02);
    rd_chk("status_w1c", 8'h04, 32'h08);

    // Interrupt.
    wb_write(8'h00, 32'h9);
    stage(0, 16'h0002);
    commit(1'b1);
    wb_write(8'h00, 32'hB);
    wait_issue(s);
    give_result(res_of(s), 0, c1);
    chk("irq_set", 32'(irq_o), 32'd1);
    wb_write(8'h04, 32'h02);
    chk("irq_clr", 32'(irq_o), 32'd0);

    // Continuous mode with overflow.
    core_ready_i = 1'b0;
    wb_write(8'h00, 32'h5);
    stage(0, 16'h0021);
    commit(1'b1);
    chk("valid_lat_t1", 32'(core_valid_o), 32'd0);
    @(posedge clk); #1;
    chk("valid_lat_t2", 32'(core_valid_o), 32'd1);
    for (int n = 2; n <= 5; n++) begin
      stage(0, 16'h0020 + 16'(n));
      commit(n <= 4);
    end
    rd_chk("status_ovf", 8'h04, 32'h0415);
    for (int n = 0; n < 4; n++) begin
      wait_issue(s);
      give_result(res_of(s), 0, c1);
    end
    repeat (3) @(negedge clk);
    rd_chk("status_drained", 8'h04, 32'h1A);
    rd_chk("res_cont0", 8'h80, 32'h2D);
    rd_chk("res_cont3", 8'h8C, 32'h30);
    wb_write(8'h04, 32'h12);
    rd_chk("status_w1c2", 8'h04, 32'h08);

    // Disable while waiting for a result.
    wb_write(8'h00, 32'h1);
    stage(0, 16'h0040);
    commit(1'b1);
    wb_write(8'h00, 32'h3);
    wait_issue(s);
    chk("in_wait", 32'(core_ready_o), 32'd1);
    commit(1'b0);
    rd_chk("status_wait", 8'h04, 32'h0101);
    wb_write(8'h00, 32'h0);
    @(posedge clk); #1;
    chk("dis_core_rst_n", 32'(core_rst_n_o), 32'd0);
    chk("dis_ready", 32'(core_ready_o), 32'd0);
    rd_chk("dis_status", 8'h04, 32'h08);
    rd_chk("dis_res_kept", 8'h80, 32'h2D);
    rd_chk("dis_stg_kept", 8'h10, 32'h40);
    wb_write(8'h00, 32'h1);
    @(posedge clk); #1;
    chk("reen_core_rst_n", 32'(core_rst_n_o), 32'd1);

    // Two results exactly 100 cycles apart.
    commit(1'b1);
    wb_write(8'h00, 32'h3);
    wait_issue(s);
    give_result(res_of(s), 0, c1);
    wb_cycle(8'h0C, 32'd0, 1'b0, t1);
    commit(1'b1);
    wb_write(8'h00, 32'h3);
    wait_issue(s);
    give_result(res_of(s), c1 + 100, c2);
    wb_cycle(8'h0C, 32'd0, 1'b0, t2);
    rd_chk("res_ts", 8'h80, 32'h49);
`ifdef ATT_WB_TIMESTAMP_EN
    chk("ts_diff", t2 - t1, 32'd100);
`else
    chk("ts_zero1", t1, 32'd0);
    chk("ts_zero2", t2, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
